led_sequencer: RTL
==================

# led_sequencer

Memory-mapped controller that owns the board's 16-bit LED bank and schedules what the bank displays. It sits between the MemOrIO LED chip-select path and the physical LEDs, and accepts CPU stores into a data register and a mode register. A tick-driven pattern engine (blink, scroll, count) sequences the displayed value, and CPU stores always take priority over engine ticks.

## Interface
Parameters:
- TICK_DIV, default 12_500_000: led_clk cycles per pattern tick; legal range 2..2^24.
- CNT_W, default 24: width of the tick divider counter.

Ports:
- led_clk  in  1  clock; all state updates on the rising edge.
- ledrst  in  1  reset, asynchronous, active-low.
- ledcs  in  1  CPU store strobe for the LED region; a write is taken on every cycle it is high.
- ledaddr  in  2  store target:
  - 2'b00 and 2'b10: data register.
  - 2'b01: mode register.
  - 2'b11: reserved; the store is ignored.
- ledwdata  in  16  store data.
- hold  in  1  freeze request from a board switch.
- ledout  out  16  registered value driven to the LEDs.
- busy  out  1  high when the mode is not DIRECT.
- tick  out  1  one-cycle pulse each time the divider expires.

## Operation
- Registers:
  - data_r[15:0], the CPU value.
  - pat_r[15:0], the working pattern; ledout is driven from pat_r.
  - mode_r[1:0].
  - div_r[CNT_W-1:0].
  - FSM state.
- Mode encoding, taken from ledwdata[1:0] on a mode write; bits 15:2 are ignored:
  - 00 DIRECT
  - 01 BLINK
  - 10 SCROLL
  - 11 COUNT
- FSM states: S_DIRECT, S_BLINK_ON, S_BLINK_OFF, S_SCROLL, S_COUNT.
- Mode write:
  - pat_r <= data_r.
  - div_r <= 0.
  - Next state: S_DIRECT, S_BLINK_ON, S_SCROLL or S_COUNT, according to the mode written.
- Data write:
  - data_r <= ledwdata and pat_r <= ledwdata.
  - div_r <= 0.
  - In BLINK the state goes to S_BLINK_ON; other modes keep their state.
- Tick behaviour, applied only when there is no CPU write and hold=0:
  - S_DIRECT: the tick is ignored and pat_r is held.
  - S_BLINK_ON: pat_r <= 0, go to S_BLINK_OFF.
  - S_BLINK_OFF: pat_r <= data_r, go to S_BLINK_ON.
  - S_SCROLL: pat_r <= {pat_r[14:0], pat_r[15]} (rotate left).
  - S_COUNT: pat_r <= pat_r + 1, modulo 2^16; 16'hFFFF wraps to 16'h0000.
- Divider:
  - div_r increments each cycle while hold=0.
  - When div_r == TICK_DIV-1: tick=1 and div_r <= 0.
  - In S_DIRECT the divider still runs and tick still pulses.
- hold=1:
  - div_r and pat_r are frozen and tick=0.
  - CPU writes still apply in full, including loading pat_r and clearing div_r.
- busy = (mode_r != DIRECT), derived from the registered state.

## Timing
- Reset (ledrst=0, asynchronous):
  - ledout=0, data_r=0, pat_r=0, mode_r=DIRECT, state=S_DIRECT.
  - div_r=0, tick=0, busy=0.
  - Reset asserted mid-pattern aborts the pattern immediately.
  - After release, the first tick occurs TICK_DIV cycles later.
- Write latency: a store sampled at edge N is visible on ledout after edge N, i.e. one cycle of latency.
- Tick latency: a tick at edge N updates ledout at the same edge N; the tick output is registered and is high during the cycle following edge N.
- Simultaneous CPU write and tick: the write wins, the tick is dropped, and div_r restarts from 0.
- Back-to-back stores: each cycle's store applies in order; the last one wins.
- ledaddr=2'b11: no state change and no divider reset.
- Tick spacing: exactly TICK_DIV cycles between ticks when there are no writes and no hold.

## Test plan
Run with TICK_DIV=4.
1. Reset, then data write 16'hA5A5 at addr 00 -> ledout=16'hA5A5 one cycle later; busy=0; ledout is unchanged across 20 cycles while tick keeps pulsing.
2. Data 16'h00FF, then mode write 01 -> ledout sequence 00FF, 0000, 00FF at 4-cycle intervals; busy=1.
3. Data 16'h8001, mode 10 -> ledout 8001, 0003, 0006, 000C on successive ticks.
4. Data 16'hFFFE, mode 11 -> ledout FFFE, FFFF, 0000, 0001 (wrap at FFFF).
5. SCROLL running, hold=1 for 10 cycles -> no tick and ledout frozen; a data write 16'h0F00 during hold -> ledout=0F00 next cycle; after hold drops, the next tick comes 4 cycles later and gives 1E00.
6. Data write issued on the tick cycle in COUNT -> ledout equals the written value (no increment) and the next tick is 4 cycles later. Separately, ledrst pulsed mid-BLINK -> ledout=0 and busy=0 immediately.

Source files
------------

// File: rtl/led_sequencer.sv
// LED bank controller: CPU-written data/mode registers plus a tick-driven
// pattern engine (blink, scroll, count). CPU stores always beat engine ticks.
module led_sequencer #(
    parameter int TICK_DIV = 12_500_000,
    parameter int CNT_W    = 24
) (
    input  logic        led_clk,
    input  logic        ledrst,
    input  logic        ledcs,
    input  logic [1:0]  ledaddr,
    input  logic [15:0] ledwdata,
    input  logic        hold,
    output logic [15:0] ledout,
    output logic        busy,
    output logic        tick
);

    typedef enum logic [2:0] {
        S_DIRECT,
        S_BLINK_ON,
        S_BLINK_OFF,
        S_SCROLL,
        S_COUNT
    } state_t;

    localparam logic [1:0]       M_DIRECT = 2'b00;
    localparam logic [1:0]       M_BLINK  = 2'b01;
    localparam logic [1:0]       M_SCROLL = 2'b10;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(TICK_DIV - 1);

    state_t           state;
    logic [15:0]      data_r;
    logic [15:0]      pat_r;
    logic [1:0]       mode_r;
    logic [CNT_W-1:0] div_r;
    logic             tick_r;

    logic data_wr;
    logic mode_wr;
    logic div_hit;

    // Addresses 00 and 10 both alias the data register; 11 is dead space.
    assign data_wr = ledcs && !ledaddr[0];
    assign mode_wr = ledcs && (ledaddr == 2'b01);
    assign div_hit = (div_r == DIV_LAST);

    always_ff @(posedge led_clk or negedge ledrst) begin
        if (!ledrst) begin
            state  <= S_DIRECT;
            data_r <= 16'h0000;
            pat_r  <= 16'h0000;
            mode_r <= M_DIRECT;
            div_r  <= '0;
            tick_r <= 1'b0;
        end else begin
            tick_r <= 1'b0;
            if (mode_wr) begin
                mode_r <= ledwdata[1:0];
                pat_r  <= data_r;
                div_r  <= '0;
                case (ledwdata[1:0])
                    M_DIRECT: state <= S_DIRECT;
                    M_BLINK:  state <= S_BLINK_ON;
                    M_SCROLL: state <= S_SCROLL;
                    default:  state <= S_COUNT;
                endcase
            end else if (data_wr) begin
                data_r <= ledwdata;
                pat_r  <= ledwdata;
                div_r  <= '0;
                if (state == S_BLINK_OFF) begin
                    state <= S_BLINK_ON;
                end
            end else if (!hold) begin
                if (div_hit) begin
                    div_r  <= '0;
                    tick_r <= 1'b1;
                    case (state)
                        S_DIRECT: begin
                        end
                        S_BLINK_ON: begin
                            pat_r <= 16'h0000;
                            state <= S_BLINK_OFF;
                        end
                        S_BLINK_OFF: begin
                            pat_r <= data_r;
                            state <= S_BLINK_ON;
                        end
                        S_SCROLL: pat_r <= {pat_r[14:0], pat_r[15]};
                        S_COUNT:  pat_r <= pat_r + 16'd1;
                        default:  state <= S_DIRECT;
                    endcase
                end else begin
                    div_r <= div_r + 1'b1;
                end
            end
        end
    end

    assign ledout = pat_r;
    assign busy   = (mode_r != M_DIRECT);
    assign tick   = tick_r;

endmodule
